// File: rtl/snd_rom_pkg.sv
// Shared types and constants for the sound ROM arbiter.
// Address/data widths, FSM state encoding and the owner encoding.
package snd_rom_pkg;

  localparam int AW = 12;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/snd_rom_prio.sv
// Winner select for the ROM arbiter: fixed priority to A, with a starvation guard for B.
// Combinational select; the starve counter updates only on a grant edge.
module snd_rom_prio
  import snd_rom_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic grant_i,
  output logic win_o
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          forced;
  logic          b_wins;

  // With STARVE_MAX of zero the guard never fires and A always wins a tie.
  assign forced = (STARVE_MAX != 0) && (cnt_q == CNT_MAX);
  assign b_wins = b_req_i && (!a_req_i || forced);
  assign win_o  = b_wins ? OWN_B : OWN_A;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      if (b_wins || !b_req_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snd_rom_arbiter.sv
// Two-port arbiter for the synchronous sound ROM; ack ROM_LAT+1 cycles after the grant edge.
// One access per ROM_LAT+3 cycles; a requester waits with req held until its one-cycle ack.
module snd_rom_arbiter
  import snd_rom_pkg::*;
#(
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy,
  output logic          owner
);

  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          grant;
  logic          win;

  assign grant = (state_q == IDLE) && (a_req || b_req);

  snd_rom_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_req_i(a_req),
    .b_req_i(b_req),
    .grant_i(grant),
    .win_o  (win)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = win;
          addr_d  = (win == OWN_B) ? b_addr : a_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LW'(ROM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (owner_q == OWN_B) begin
            b_rdata_d = rom_data;
            b_ack_d   = 1'b1;
          end else begin
            a_rdata_d = rom_data;
            a_ack_d   = 1'b1;
          end
          state_d = DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      // The bubble here lets a requester drop req after its ack before re-arbitration.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      owner_q   <= OWN_A;
      addr_q    <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign rom_cs   = (state_q == ISSUE) || (state_q == WAIT);
  assign rom_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_snd_rom_arbiter.sv
// Scoreboarded bench for snd_rom_arbiter with a behavioural rom_snd (ROM_LAT=1).
// A second instance with STARVE_MAX=0 shares the request inputs to check strict A priority.
module tb_snd_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [11:0] a_addr, b_addr;
  logic        a_ack, b_ack, rom_cs, busy, owner;
  logic [7:0]  a_rdata, b_rdata, rom_data;
  logic [11:0] rom_addr;

  logic        z_a_ack, z_b_ack, z_rom_cs, z_busy, z_owner;
  logic [7:0]  z_a_rdata, z_b_rdata, z_rom_data;
  logic [11:0] z_rom_addr;

  int checks   = 0;
  int failures = 0;
  int z_a_acks = 0;
  int z_b_acks = 0;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_a, last_b;

  always #5 clk = ~clk;

  snd_rom_arbiter #(.ROM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .owner(owner)
  );

  snd_rom_arbiter #(.ROM_LAT(1), .STARVE_MAX(0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(z_a_ack), .a_rdata(z_a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ack(z_b_ack), .b_rdata(z_b_rdata),
    .rom_cs(z_rom_cs), .rom_addr(z_rom_addr), .rom_data(z_rom_data),
    .busy(z_busy), .owner(z_owner)
  );

  function automatic logic [7:0] rom_val(input logic [11:0] a);
    case (a)
      12'h000: rom_val = 8'h76;
      12'h001: rom_val = 8'h28;
      12'h002: rom_val = 8'h43;
      12'h003: rom_val = 8'h29;
      12'h7FF: rom_val = 8'h91;
      12'h800: rom_val = 8'h06;
      12'h801: rom_val = 8'h22;
      12'h803: rom_val = 8'h96;
      12'hFFF: rom_val = 8'h1D;
      default: rom_val = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // rom_snd: synchronous read, one edge from address sample to data valid
  always @(posedge clk) if (rom_cs) rom_data <= rom_val(rom_addr);
  always @(posedge clk) if (z_rom_cs) z_rom_data <= rom_val(z_rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // sel: 0 = a_ack, 1 = b_ack, 2 = either; n counts negedges until the ack is seen
  task automatic wait_ack(input int sel, output int n, output int cs_n);
    bit   done;
    logic hit;
    n = 0; cs_n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (rom_cs) cs_n++;
      hit = (sel == 0) ? a_ack : (sel == 1) ? b_ack : (a_ack | b_ack);
      if (hit === 1'b1) begin
        done = 1'b1;
      end else if (n >= 20) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout: no ack for sel %0d after %0d cycles", sel, n);
        done = 1'b1;
      end
    end
  endtask

  task automatic push(input logic port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every ack, checks data, port, owner and rdata hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (z_a_ack) z_a_acks++;
    if (z_b_ack) z_b_acks++;
    if (!rst_n) begin
      last_a = '0;
      last_b = '0;
    end else if (a_ack || b_ack) begin
      chk("dual_ack", {31'd0, a_ack & b_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_ack: a_ack=%0b b_ack=%0b with nothing expected", a_ack, b_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'd0, b_ack}, {31'd0, e.port});
        chk("owner_at_ack", {31'd0, owner}, {31'd0, e.port});
        if (b_ack) begin
          chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.data});
          chk("a_rdata_hold", {24'd0, a_rdata}, {24'd0, last_a});
          last_b = e.data;
        end else begin
          chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.data});
          chk("b_rdata_hold", {24'd0, b_rdata}, {24'd0, last_b});
          last_a = e.data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cs_n, zb0, za0, acks;
    logic [11:0] b_addrs[3];
    logic [7:0]  b_datas[3];
    b_addrs = '{12'h7FF, 12'h800, 12'hFFF};
    b_datas = '{8'h91, 8'h06, 8'h1D};

    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single A read: ack on the third negedge after driving (two cycles after the sampling edge)
    push(1'b0, 8'h76);
    a_addr = 12'h000; a_req = 1'b1;
    wait_ack(0, n, cs_n);
    a_req = 1'b0;
    chk("single_latency", n, 3);
    chk("single_cs_cycles", cs_n, 2);
    repeat (2) @(negedge clk);

    // A held for back-to-back reads, four cycles per access
    push(1'b0, 8'h28); push(1'b0, 8'h43); push(1'b0, 8'h29);
    a_addr = 12'h001; a_req = 1'b1;
    wait_ack(0, n, cs_n);
    chk("b2b_first_latency", n, 3);
    a_addr = 12'h002;
    wait_ack(0, n, cs_n);
    chk("b2b_spacing_1", n, 4);
    a_addr = 12'h003;
    wait_ack(0, n, cs_n);
    chk("b2b_spacing_2", n, 4);
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    // B alone across the address range
    for (int i = 0; i < 3; i++) begin
      push(1'b1, b_datas[i]);
      b_addr = b_addrs[i]; b_req = 1'b1;
      wait_ack(1, n, cs_n);
      b_req = 1'b0;
      chk("b_latency", n, 3);
      chk("b_owner", {31'd0, owner}, 32'd1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Contention: A,A,A,A,B repeating on the guarded instance; strict instance never serves B
    zb0 = z_b_acks; za0 = z_a_acks;
    for (int i = 0; i < 10; i++) push((i % 5) == 4, ((i % 5) == 4) ? 8'h96 : 8'h22);
    a_addr = 12'h801; b_addr = 12'h803;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 10; i++) wait_ack(2, n, cs_n);
    a_req = 1'b0; b_req = 1'b0;
    chk("strict_b_acks", z_b_acks - zb0, 0);
    chk("strict_a_served", {31'd0, (z_a_acks - za0) >= 9}, 32'd1);
    repeat (4) @(negedge clk);

    // Reset during WAIT of an A read abandons the access
    a_addr = 12'h000; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_cs", {31'd0, rom_cs}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cs", {31'd0, rom_cs}, 32'd0);
    chk("mid_rst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("mid_rst_b_rdata", {24'd0, b_rdata}, 32'd0);
    chk("mid_rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    chk("post_rst_acks", acks, 0);
    push(1'b0, 8'h76);
    a_addr = 12'h000; a_req = 1'b1;
    wait_ack(0, n, cs_n);
    a_req = 1'b0;
    chk("post_rst_latency", n, 3);
    repeat (2) @(negedge clk);

    // a_req dropped and address changed right after grant; access still completes
    push(1'b0, 8'h43);
    a_addr = 12'h002; a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0; a_addr = 12'hFFF;
    wait_ack(0, n, cs_n);
    chk("drop_latency", n, 2);
    @(negedge clk);
    chk("drop_busy_idle", {31'd0, busy}, 32'd0);
    chk("drop_cs_idle", {31'd0, rom_cs}, 32'd0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snd_rom_arbiter.md
Name: snd_rom_arbiter

Overview:
- Shares the single synchronous sound ROM (rom_snd: 4 KB, 12-bit address, 8-bit data) between two requesters.
- Port A is the 6808 sound CPU fetch path. Port B is the ROM checksum/self-test scanner.
- Sequences each access: it drives rom_cs/rom_addr, waits the ROM latency, captures data and returns it with a one-cycle ack.
- Fixed priority to A, with a starvation guard that guarantees B periodic access.

Parameters:
- AW, 12, ROM address width.
- DW, 8, ROM data width.
- ROM_LAT, 1, clock edges from the ROM sampling address to data valid (must be ≥1).
- STARVE_MAX, 4, consecutive A grants tolerated while B is pending before B is forced; 0 means strict A priority.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req  in  1  port A read request; held until a_ack.
- a_addr  in  AW  port A address; stable while a_req is high.
- a_ack  out  1  one-cycle pulse; a_rdata valid that cycle.
- a_rdata  out  DW  port A read data; holds until the next A ack.
- b_req  in  1  port B read request.
- b_addr  in  AW  port B address.
- b_ack  out  1  one-cycle pulse; b_rdata valid.
- b_rdata  out  DW  port B read data; held.
- rom_cs  out  1  ROM chip select.
- rom_addr  out  AW  ROM address.
- rom_data  in  DW  ROM data.
- busy  out  1  access in flight (state ≠ IDLE).
- owner  out  1  current or last grant (0 = A, 1 = B).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: all acks, rom_cs, busy and owner are 0; rom_addr, a_rdata and b_rdata are 0.
  - Internal: state goes to IDLE and the starve counter to 0.
  - Reset mid-access abandons the access; no ack is issued after release.
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - If either request is high at an edge, arbitrate and register the winner into owner.
  - Latch the winner's address into rom_addr, assert rom_cs, and go to ISSUE.
- Arbitration:
  - Only A requesting → A. Only B requesting → B.
  - Both requesting → A, unless STARVE_MAX ≠ 0 and starve_cnt = STARVE_MAX, in which case B wins.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Increments on each A grant made while b_req is high.
  - Clears on any B grant, or when an A grant is made with b_req low.
  - Saturates at STARVE_MAX.
- ISSUE: the ROM samples rom_addr at this edge; load the latency counter with ROM_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter.
  - When it is 0, capture rom_data into the owner's rdata register, pulse the owner's ack, and go to DONE.
  - rom_cs stays high from ISSUE through WAIT.
- DONE: deassert rom_cs and go to IDLE. One idle bubble is required so a requester can drop req after ack.
- Latency and throughput:
  - The request is sampled at edge E0; ack is high in the cycle following edge E(ROM_LAT+1). With ROM_LAT=1 that is 2 cycles.
  - Throughput is one access per ROM_LAT+3 cycles.
- Requester handshake:
  - A requester holding req high through DONE is treated as a new request at the next IDLE arbitration.
  - A requester dropping req before its ack (protocol violation): the access completes and the ack is still pulsed.
  - Changes to the address while the access is in flight are ignored, because the address was latched at grant.
- A and B acks are never high in the same cycle.
- rdata registers change only on their own port's ack.
- Address wrap: none; the full 0x000–0xFFF range is passed unmodified.

Decomposition:
- Package snd_rom_pkg holds:
  - Parameters AW and DW.
  - State enum {IDLE, ISSUE, WAIT, DONE}.
  - Owner encodings OWN_A=0 and OWN_B=1.
- Sub-module snd_rom_prio holds the combinational winner select plus the starve counter register. It is instantiated once.
- The FSM, latency counter and data capture live in the top level.

Test Plan:
- Bench instantiates rom_snd with ROM_LAT=1.
- A single read at 0x000 → a_ack exactly 2 cycles after req is sampled, a_rdata=0x76, b_ack stays 0, rom_cs high for 2 cycles.
- A back-to-back reads with a_req held, addresses 0x001, 0x002, 0x003 → a_rdata 0x28, 0x43, 0x29 on consecutive acks spaced 4 cycles apart.
- B alone reads 0x7FF, 0x800 and 0xFFF → b_rdata 0x91, 0x06, 0x1D; owner=1; a_rdata unchanged.
- A and B both held continuously (A at 0x801, B at 0x803), STARVE_MAX=4 → grant order A,A,A,A,B repeating; b_rdata=0x96, a_rdata=0x22; never both acks in one cycle. With STARVE_MAX=0 → b_ack never asserted.
- rst_n pulsed low during WAIT of an A read → outputs zero immediately; no ack after release; the next A read of 0x000 returns 0x76 normally.
- a_req dropped one cycle after grant → the access still completes with a_ack and the correct data; the arbiter then returns to IDLE with busy=0.
